unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 23 ++
 rtl/unidade_controle_decod_opcode.sv | 27 ++
 rtl/unidade_controle.sv | 136 +++++++++++++
 tb/tb_unidade_controle.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared constants for the control unit: opcode values, FSM state encoding and
// the default width of the retired-instruction counter.
package unidade_controle_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

endpackage

// File: rtl/unidade_controle_decod_opcode.sv
// Combinational opcode classifier: legality plus the class bits the FSM needs.
module decod_opcode
  import unidade_controle_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       uses_imm
);

  logic is_opimm;
  logic is_op;

  always_comb begin
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_opimm  = (opcode == OPC_OPIMM);
    is_op     = (opcode == OPC_OP);
    is_branch = (opcode == OPC_BRANCH);
    legal     = is_load | is_store | is_opimm | is_op | is_branch;
    // Operand B comes from the immediate for these classes; OP and BRANCH use doutB.
    uses_imm  = is_load | is_store | is_opimm;
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-opcode
// trap and a wrapping retired-instruction counter.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             flag,
  output logic             we_ir,
  output logic             we_pc,
  output logic             we_reg,
  output logic             we_mem,
  output logic             sel_mux1,
  output logic             sel_mux2,
  output logic             pc_src,
  output logic             busy,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  logic [6:0] dec_in;
  logic       legal, is_load, is_store, is_branch, uses_imm;

  // Single decoder: sees the live opcode while deciding legality, the captured one afterwards.
  assign dec_in = (state_q == S_DECODE) ? opcode : op_q;

  decod_opcode u_decod (
    .opcode    (dec_in),
    .legal     (legal),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .uses_imm  (uses_imm)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_branch)               retire  = 1'b1;
        else if (is_load | is_store) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        if (is_store) retire  = 1'b1;
        else          state_d = S_WB;
      end
      S_WB:     retire  = 1'b1;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    if (retire) begin
      state_d = run ? S_FETCH : S_IDLE;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode from state and captured opcode; only pc_src in EXEC tracks flag live.
  always_comb begin
    we_ir    = 1'b0;
    we_pc    = 1'b0;
    we_reg   = 1'b0;
    we_mem   = 1'b0;
    sel_mux1 = 1'b0;
    sel_mux2 = 1'b0;
    pc_src   = 1'b0;
    busy     = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        we_ir = 1'b1;
        busy  = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy     = 1'b1;
        sel_mux1 = ~uses_imm;
        if (is_branch) begin
          we_pc  = 1'b1;
          pc_src = flag;
        end
      end
      S_MEM: begin
        busy = 1'b1;
        if (is_store) begin
          we_mem = 1'b1;
          we_pc  = 1'b1;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        we_reg   = 1'b1;
        we_pc    = 1'b1;
        sel_mux1 = ~uses_imm;
        sel_mux2 = is_load;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized self-checking bench for unidade_controle (default width and a 4-bit counter copy).
module tb_unidade_controle;
  import unidade_controle_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic [6:0] opcode;
  logic flag;

  logic we_ir, we_pc, we_reg, we_mem, sel_mux1, sel_mux2, pc_src, busy, trap;
  logic [2:0] state;
  logic [15:0] cnt16;

  logic we_ir4, we_pc4, we_reg4, we_mem4, sel_mux14, sel_mux24, pc_src4, busy4, trap4;
  logic [2:0] state4;
  logic [3:0] cnt4;

  logic [11:0] obs;
  int unsigned cnt_model;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unidade_controle u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .flag(flag),
    .we_ir(we_ir), .we_pc(we_pc), .we_reg(we_reg), .we_mem(we_mem),
    .sel_mux1(sel_mux1), .sel_mux2(sel_mux2), .pc_src(pc_src),
    .busy(busy), .trap(trap), .state(state), .instr_count(cnt16)
  );

  unidade_controle #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .flag(flag),
    .we_ir(we_ir4), .we_pc(we_pc4), .we_reg(we_reg4), .we_mem(we_mem4),
    .sel_mux1(sel_mux14), .sel_mux2(sel_mux24), .pc_src(pc_src4),
    .busy(busy4), .trap(trap4), .state(state4), .instr_count(cnt4)
  );

  assign obs = {state, we_ir, we_pc, we_reg, we_mem, sel_mux1, sel_mux2, pc_src, busy, trap};

  // Reference: per-instruction cycle count and the outputs each cycle should show.
  function automatic int lat(input logic [6:0] op);
    if (op == OPC_BRANCH) return 3;
    if (op == OPC_LOAD) return 5;
    return 4;
  endfunction

  function automatic logic [11:0] exp_outs(input logic [6:0] op, input logic fl, input int k);
    int L;
    logic last;
    logic [2:0] st;
    L = lat(op);
    last = (k == L);
    case (k)
      1: st = 3'd1;
      2: st = 3'd2;
      3: st = 3'd3;
      4: st = (op == OPC_LOAD || op == OPC_STORE) ? 3'd4 : 3'd5;
      default: st = 3'd5;
    endcase
    return {st, (k == 1), last,
            last && (op != OPC_STORE) && (op != OPC_BRANCH),
            last && (op == OPC_STORE),
            (k >= 3) && (op == OPC_OP || op == OPC_BRANCH),
            last && (op == OPC_LOAD),
            last && (op == OPC_BRANCH) && fl,
            1'b1, 1'b0};
  endfunction

  task automatic drive_instr(input logic [6:0] op, input logic fl, input logic run_after,
                             input int abort_at);
    int L;
    logic [11:0] e;
    bit aborted;
    aborted = 0;
    L = lat(op);
    opcode = op;
    flag = fl;
    run = 1'b1;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      e = exp_outs(op, fl, k);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL outs op=%b k=%0d got %b want %b", op, k, obs, e);
      end
      n_cmp++;
      if (cnt16 !== cnt_model[15:0] || cnt4 !== cnt_model[3:0] || state4 !== e[11:9]) begin
        n_bad++;
        $display("FAIL count op=%b k=%0d got %0d/%0d st4=%0d want %0d/%0d st4=%0d",
                 op, k, cnt16, cnt4, state4, cnt_model[15:0], cnt_model[3:0], e[11:9]);
      end
      if (k == 3) begin
        run = run_after;
        if (op == OPC_BRANCH) begin
          flag = ~fl;
          #1;
          n_cmp++;
          if (pc_src !== ~fl) begin
            n_bad++;
            $display("FAIL pc_src_follow got %b want %b", pc_src, ~fl);
          end
          flag = fl;
          #1;
        end
      end
      if (k >= 3 && k < L) opcode = 7'($urandom);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 12'b0 || cnt16 !== 16'd0 || cnt4 !== 4'd0 || state4 !== 3'd0) begin
          n_bad++;
          $display("FAIL async_reset got %b cnt %0d/%0d want all zero", obs, cnt16, cnt4);
        end
        cnt_model = 0;
        run = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== 12'b0 || cnt16 !== 16'd0) begin
          n_bad++;
          $display("FAIL post_release got %b cnt %0d want IDLE zeros", obs, cnt16);
        end
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      cnt_model++;
      if (!run_after) begin
        @(negedge clk);
        n_cmp++;
        if (obs !== 12'b0 || cnt16 !== cnt_model[15:0] || cnt4 !== cnt_model[3:0]) begin
          n_bad++;
          $display("FAIL idle_after got %b cnt %0d want 0 cnt %0d", obs, cnt16, cnt_model[15:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    opcode = OPC_OP;
    flag = 1'b0;
    cnt_model = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 12'b0 || cnt16 !== 16'd0 || cnt4 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state got %b cnt %0d want all zero", obs, cnt16);
    end
    run = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset got %b want 0", obs);
    end
  endtask

  task automatic test_branch();
    drive_instr(OPC_BRANCH, 1'b1, 1'b1, 0);
    drive_instr(OPC_BRANCH, 1'b0, 1'b0, 0);
  endtask

  task automatic test_load();
    drive_instr(OPC_LOAD, 1'b1, 1'b0, 0);
  endtask

  task automatic test_store();
    drive_instr(OPC_STORE, 1'b0, 1'b1, 0);
    drive_instr(OPC_OPIMM, 1'b1, 1'b0, 0);
  endtask

  task automatic test_run_drop();
    drive_instr(OPC_OP, 1'b1, 1'b0, 0);
  endtask

  task automatic test_trap();
    logic [11:0] e;
    opcode = 7'b1111111;
    flag = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      e = exp_outs(OPC_OP, 1'b0, k);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL trap_pre k=%0d got %b want %b", k, obs, e);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      opcode = OPC_BRANCH;
      n_cmp++;
      if (obs !== {3'd6, 8'b0, 1'b1} || cnt16 !== cnt_model[15:0]) begin
        n_bad++;
        $display("FAIL trap_hold got %b cnt %0d want %b cnt %0d",
                 obs, cnt16, {3'd6, 8'b0, 1'b1}, cnt_model[15:0]);
      end
    end
    run = 1'b0;
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    cnt_model = 0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'b0 || cnt16 !== 16'd0) begin
      n_bad++;
      $display("FAIL trap_exit got %b cnt %0d want IDLE zeros", obs, cnt16);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) drive_instr(OPC_BRANCH, 1'($urandom), (i != 15), 0);
    n_cmp++;
    if (cnt4 !== 4'd0 || cnt16 !== 16'd16) begin
      n_bad++;
      $display("FAIL wrap got %0d/%0d want 0/16", cnt4, cnt16);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [5];
    ops = '{OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_BRANCH};
    for (int i = 0; i < 40; i++)
      drive_instr(ops[$urandom_range(0, 4)], 1'($urandom), ($urandom_range(0, 3) != 0), 0);
  endtask

  task automatic test_reset_mid_mem();
    drive_instr(OPC_LOAD, 1'b0, 1'b1, 4);
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load();
    test_store();
    test_run_drop();
    test_trap();
    test_wrap();
    test_back_to_back();
    test_reset_mid_mem();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
